frame_scheduler: RTL and testbench

- Upstream stage of the 8x8 matrix display driver. Holds a double-buffered gs x gs frame and supplies the flat matrix vector and the scan-enable to the display driver.
- Starts one gs-row scan every REFRESH_CYC clocks, checks the driver's scan-done flag, and swaps front/back buffers only in the blank gap between scans, so the driver never sees a frame change mid-scan.
- Game logic writes rows into the back buffer through a simple row-write port.

---
 rtl/frame_scheduler_pkg.sv | 19 +
 rtl/frame_bank_pair.sv | 58 +++++
 rtl/frame_scheduler.sv | 126 ++++++++++++
 tb/tb_frame_scheduler.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/frame_scheduler_pkg.sv
// Shared definitions for the frame scheduler: default matrix size,
// row-index width helper, scheduler state encoding, frame counter width.
package frame_scheduler_pkg;

    localparam int GS_DEF = 8;
    localparam int FCNT_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_CHECK = 2'd2
    } state_t;

    // Width of a row index for an n-row matrix (at least one bit).
    function automatic int row_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/frame_bank_pair.sv
// Double-buffered gs x gs frame store: two banks, a select bit, a row
// write port into the back bank, and the front-bank output mux.
//   clk_i, rst_i    : clock, async active-high reset
//   wr_en_i         : write wr_data_i into back-bank row wr_row_i
//   wr_row_i        : back-bank row index (rows >= gs are ignored)
//   wr_data_i       : row data, bit c = column c
//   swap_i          : toggle front/back selection at this edge
//   matrix_o        : front bank, bit gs*r+c = row r, column c
module frame_bank_pair
    import frame_scheduler_pkg::*;
#(
    parameter int gs = GS_DEF
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  wr_en_i,
    input  logic [row_w(gs)-1:0]  wr_row_i,
    input  logic [gs-1:0]         wr_data_i,
    input  logic                  swap_i,
    output logic [gs*gs-1:0]      matrix_o
);

    logic [gs-1:0] r_bank [2][gs];
    logic          r_sel;
    logic          w_back;
    logic          w_row_ok;

    assign w_back   = ~r_sel;
    assign w_row_ok = (32'(wr_row_i) < 32'(gs));

    // The write uses the pre-swap back bank, so a write coinciding with
    // a swap ends up in the bank that becomes front.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int b = 0; b < 2; b++) begin
                for (int r = 0; r < gs; r++) begin
                    r_bank[b][r] <= '0;
                end
            end
            r_sel <= 1'b0;
        end else begin
            if (wr_en_i && w_row_ok) begin
                r_bank[w_back][wr_row_i] <= wr_data_i;
            end
            if (swap_i) begin
                r_sel <= ~r_sel;
            end
        end
    end

    always_comb begin
        matrix_o = '0;
        for (int r = 0; r < gs; r++) begin
            matrix_o[gs*r +: gs] = r_bank[r_sel][r];
        end
    end

endmodule

// File: rtl/frame_scheduler.sv
// Display frame scheduler: starts a gs-row scan every REFRESH_CYC clocks,
// checks the driver's done flag and swaps buffers only between scans.
//   clk_i, rst_i         : clock, async active-high reset
//   enable_i             : scanning allowed
//   wr_en_i/wr_row_i/
//   wr_data_i            : back-buffer row write port
//   swap_req_i           : pulse requesting a back->front swap
//   d_disp_i             : scan-done flag from the display driver
//   matrix_o             : front frame
//   e_disp_o             : scan enable to the driver (gs cycles)
//   swap_ack_o           : pulse, cycle after a swap
//   scan_err_o           : sticky, driver not done at scan end
//   frame_cnt_o          : completed scans, wraps
module frame_scheduler
    import frame_scheduler_pkg::*;
#(
    parameter int gs          = GS_DEF,
    parameter int REFRESH_CYC = 1024
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  enable_i,
    input  logic                  wr_en_i,
    input  logic [row_w(gs)-1:0]  wr_row_i,
    input  logic [gs-1:0]         wr_data_i,
    input  logic                  swap_req_i,
    input  logic                  d_disp_i,
    output logic [gs*gs-1:0]      matrix_o,
    output logic                  e_disp_o,
    output logic                  swap_ack_o,
    output logic                  scan_err_o,
    output logic [FCNT_W-1:0]     frame_cnt_o
);

    localparam int RW    = row_w(gs);
    localparam int CNT_W = (REFRESH_CYC > 1) ? $clog2(REFRESH_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_CYC - 1);
    localparam logic [RW-1:0]    RC_LAST  = RW'(gs - 1);

    state_t             r_state;
    state_t             w_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [RW-1:0]      r_rc;
    logic               r_pend;
    logic               r_ack;
    logic               r_err;
    logic [FCNT_W-1:0]  r_fcnt;
    logic               w_scan_on;
    logic               w_check;
    logic               w_swap;

    always_comb begin
        w_next    = r_state;
        w_scan_on = 1'b0;
        w_check   = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (r_cnt == '0 && enable_i) begin
                    w_next = ST_SCAN;
                end
            end
            ST_SCAN: begin
                w_scan_on = 1'b1;
                if (r_rc == RC_LAST) begin
                    w_next = ST_CHECK;
                end
            end
            ST_CHECK: begin
                w_check = 1'b1;
                w_next  = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    assign w_swap = w_check & r_pend;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_rc    <= '0;
            r_pend  <= 1'b0;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
            r_fcnt  <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= (r_cnt == CNT_LAST) ? '0 : r_cnt + 1'b1;
            r_rc    <= (r_state == ST_SCAN) ? r_rc + 1'b1 : '0;
            // A request landing on the swap edge is absorbed by that swap.
            if (w_swap) begin
                r_pend <= 1'b0;
            end else if (swap_req_i) begin
                r_pend <= 1'b1;
            end
            r_ack <= w_swap;
            if (w_check) begin
                r_fcnt <= r_fcnt + 1'b1;
                if (!d_disp_i) begin
                    r_err <= 1'b1;
                end
            end
        end
    end

    frame_bank_pair #(
        .gs        (gs)
    ) u_banks (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .wr_en_i   (wr_en_i),
        .wr_row_i  (wr_row_i),
        .wr_data_i (wr_data_i),
        .swap_i    (w_swap),
        .matrix_o  (matrix_o)
    );

    assign e_disp_o    = w_scan_on;
    assign swap_ack_o  = r_ack;
    assign scan_err_o  = r_err;
    assign frame_cnt_o = r_fcnt;

endmodule

// File: tb/tb_frame_scheduler.sv
// Self-checking bench for frame_scheduler (gs=8, REFRESH_CYC=16)
// with a simple display-driver model and a frame-level reference.
module tb_frame_scheduler;

    localparam int GS = 8;
    localparam int R  = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          enable = 1'b0;
    logic          wr_en = 1'b0;
    logic [2:0]    wr_row = '0;
    logic [7:0]    wr_data = '0;
    logic          swap_req = 1'b0;
    logic          d_disp;
    logic [63:0]   matrix;
    logic          e_disp;
    logic          swap_ack;
    logic          scan_err;
    logic [7:0]    frame_cnt;

    int tests = 0;
    int fails = 0;

    frame_scheduler #(
        .gs          (GS),
        .REFRESH_CYC (R)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .enable_i    (enable),
        .wr_en_i     (wr_en),
        .wr_row_i    (wr_row),
        .wr_data_i   (wr_data),
        .swap_req_i  (swap_req),
        .d_disp_i    (d_disp),
        .matrix_o    (matrix),
        .e_disp_o    (e_disp),
        .swap_ack_o  (swap_ack),
        .scan_err_o  (scan_err),
        .frame_cnt_o (frame_cnt)
    );

    always #5 clk = ~clk;

    // Display driver: latches one row per enabled cycle, raises done
    // after the last row, clears it when a new scan begins.
    logic [2:0] drv_row;
    logic       drv_done;
    logic [7:0] drv_cols [8];
    bit         hold_low = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            drv_row  <= '0;
            drv_done <= 1'b0;
        end else if (e_disp) begin
            drv_cols[drv_row] <= matrix[{drv_row, 3'b000} +: 8];
            drv_row  <= drv_row + 3'd1;
            drv_done <= (drv_row == 3'd7);
        end
    end

    assign d_disp = hold_low ? 1'b0 : drv_done;

    // Reference: cycle index since reset, start cycle of latest scan,
    // front/back frames as plain row arrays exchanged on a swap.
    int         c;
    int         c0;
    logic [7:0] m_front [8];
    logic [7:0] m_back  [8];
    bit         m_pend;
    bit         m_err;
    bit         m_ack;
    int         m_fcnt;

    function automatic logic [63:0] flat_front();
        logic [63:0] v;
        for (int r = 0; r < GS; r++) v[r*8 +: 8] = m_front[r];
        return v;
    endfunction

    task automatic model_reset();
        c = 0;
        c0 = -1;
        for (int r = 0; r < GS; r++) begin
            m_front[r] = '0;
            m_back[r]  = '0;
        end
        m_pend = 0;
        m_err  = 0;
        m_ack  = 0;
        m_fcnt = 0;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        bit         s_en, s_we, s_req, s_d, is_chk, exp_e;
        logic [2:0] s_row;
        logic [7:0] s_dat, tmp;
        s_en  = enable;
        s_we  = wr_en;
        s_req = swap_req;
        s_d   = d_disp;
        s_row = wr_row;
        s_dat = wr_data;
        @(posedge clk);
        is_chk = (c0 >= 0) && (c == c0 + GS + 1);
        m_ack = 0;
        if (s_we) m_back[s_row] = s_dat;
        if (is_chk) begin
            m_fcnt = (m_fcnt + 1) % 256;
            if (!s_d) m_err = 1;
            if (m_pend) begin
                for (int r = 0; r < GS; r++) begin
                    tmp = m_front[r];
                    m_front[r] = m_back[r];
                    m_back[r] = tmp;
                end
                m_pend = 0;
                m_ack = 1;
            end else if (s_req) begin
                m_pend = 1;
            end
        end else if (s_req) begin
            m_pend = 1;
        end
        if ((c % R) == 0 && s_en) c0 = c;
        c++;
        exp_e = (c0 >= 0) && (c >= c0 + 1) && (c <= c0 + GS);
        #1;
        chk("e_disp", 64'(e_disp), 64'(exp_e));
        chk("matrix", matrix, flat_front());
        chk("swap_ack", 64'(swap_ack), 64'(m_ack));
        chk("scan_err", 64'(scan_err), 64'(m_err));
        chk("frame_cnt", 64'(frame_cnt), 64'(m_fcnt));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wait_e();
        for (int i = 0; i < 40 && !e_disp; i++) step();
        chk("wait_e_disp", 64'(e_disp), 64'd1);
    endtask

    task automatic reset_now();
        #3;
        rst      = 1'b1;
        enable   = 1'b0;
        wr_en    = 1'b0;
        swap_req = 1'b0;
        #1;
        chk("rst_e_disp", 64'(e_disp), 64'd0);
        chk("rst_matrix", matrix, 64'd0);
        chk("rst_ack", 64'(swap_ack), 64'd0);
        chk("rst_err", 64'(scan_err), 64'd0);
        chk("rst_fcnt", 64'(frame_cnt), 64'd0);
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        model_reset();
    endtask

    int acks;

    initial begin
        model_reset();
        reset_now();

        // Free-running scans with a blank frame.
        enable = 1'b1;
        run(40);

        // Diagonal pattern into back buffer, then swap.
        for (int r = 0; r < GS; r++) begin
            wr_en   = 1'b1;
            wr_row  = 3'(r);
            wr_data = 8'h01 << r;
            step();
        end
        wr_en    = 1'b0;
        swap_req = 1'b1;
        step();
        swap_req = 1'b0;
        run(34);
        for (int r = 0; r < GS; r++) begin
            chk($sformatf("drv_col%0d", r), 64'(drv_cols[r]),
                64'(8'h01 << r));
        end

        // Three merged requests mid-scan: one swap, one ack.
        wait_e();
        acks = 0;
        for (int i = 0; i < 24; i++) begin
            swap_req = (i == 1 || i == 3 || i == 5);
            step();
            acks += int'(swap_ack);
        end
        swap_req = 1'b0;
        chk("merged_acks", 64'(acks), 64'd1);

        // Randomized writes, requests and enable.
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 15) == 0) enable = ~enable;
            wr_en    = ($urandom_range(0, 2) == 0);
            wr_row   = 3'($urandom_range(0, 7));
            wr_data  = 8'($urandom);
            swap_req = ($urandom_range(0, 9) == 0);
            step();
        end
        wr_en    = 1'b0;
        swap_req = 1'b0;
        enable   = 1'b1;

        // Enable dropped at row 3: scan finishes, no new scans.
        wait_e();
        run(3);
        enable = 1'b0;
        run(40);
        chk("no_scan_while_off", 64'(e_disp), 64'd0);
        enable = 1'b1;
        run(20);

        // Driver never reports done: sticky error.
        hold_low = 1'b1;
        run(20);
        chk("err_set", 64'(scan_err), 64'd1);
        hold_low = 1'b0;
        run(20);
        chk("err_sticky", 64'(scan_err), 64'd1);

        // Asynchronous reset in the middle of a scan.
        wait_e();
        run(2);
        reset_now();
        enable = 1'b1;
        run(40);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
